// File: rtl/mux_nx1_rr_pkg.sv
// mux_pkg: default sizes and round-robin pointer helper for mux_nx1_rr
package mux_pkg;

    localparam int MUX_DEF_NCH = 4;
    localparam int MUX_DEF_DW  = 8;

    function automatic int unsigned rr_wrap_inc(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching req from ptr upward with wrap
module rr_arbiter #(
    parameter  int N_CH = 4,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic found;
    int   j;

    // First requester at or after ptr wins; j wraps without a modulo so any N_CH works
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N_CH; k++) begin
            j = int'(ptr) + k;
            j = (j >= N_CH) ? j - N_CH : j;
            if (!found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = SELW'(j);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-channel registered round-robin stream mux; MUX_RR_LAST_LOCK_EN adds packet locking on in_last
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter  int N_CH = MUX_DEF_NCH,
    parameter  int DW   = MUX_DEF_DW,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [SELW-1:0]    out_sel
);

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0] out_sel_q, out_sel_d;
    logic [SELW-1:0] ptr_q, ptr_d, ptr_nxt;
    logic [N_CH-1:0] req, gnt;
    logic [SELW-1:0] gnt_idx;
    logic            load, xfer;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign load     = !out_valid_q || out_ready;
    assign xfer     = load && (|req);
    assign in_ready = gnt & {N_CH{load && rst_n}};
    assign ptr_nxt  = SELW'(rr_wrap_inc(32'(gnt_idx), N_CH));

`ifdef MUX_RR_LAST_LOCK_EN
    logic            lock_q, lock_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;

    // A locked packet masks every other requester so the arbiter can only pick the owner
    assign req = lock_q ? (in_valid & (N_CH'(1) << lock_ch_q)) : in_valid;

    // Lock on a non-last beat, release and advance priority on the last beat
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            lock_d    = !in_last[gnt_idx];
            lock_ch_d = gnt_idx;
            ptr_d     = in_last[gnt_idx] ? ptr_nxt : ptr_q;
        end
    end

    // Lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^in_last;
    assign req         = in_valid;
    assign ptr_d       = xfer ? ptr_nxt : ptr_q;
`endif

    // Output stage: load the granted beat, drain to idle, or hold under backpressure
    always_comb begin
        out_valid_d = load ? xfer : out_valid_q;
        out_data_d  = xfer ? in_data[gnt_idx*DW +: DW] : out_data_q;
        out_sel_d   = xfer ? gnt_idx : out_sel_q;
    end

    // Output register and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// tb_mux_nx1_rr: directed scoreboard bench for mux_nx1_rr (N_CH=4 and N_CH=3 instances)
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;

    logic [2:0]  v3, r3, l3;
    logic [23:0] d3;
    logic        ov3, ordy3;
    logic [7:0]  od3;
    logic [1:0]  os3;

    logic [31:0] q4[$];
    logic [31:0] q3[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          k1;
    logic [7:0]  c1_data[3] = '{8'h21, 8'h22, 8'h23};
    logic        c1_last[3] = '{1'b0, 1'b0, 1'b1};
    logic        adv;

    always #5 clk = ~clk;

    mux_nx1_rr #(.N_CH(4), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel)
    );

    mux_nx1_rr #(.N_CH(3), .DW(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v3), .in_ready(r3), .in_data(d3), .in_last(l3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_sel(os3)
    );

    function automatic logic [31:0] pk(input int s, input int d);
        return {22'd0, s[1:0], d[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Negedge sample: every beat consumed downstream is checked against the scoreboard
    task automatic half();
        logic [31:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            e = (q4.size() != 0) ? q4.pop_front() : 'x;
            chk("sb4", pk(int'(out_sel), int'(out_data)), e);
        end
        if (ov3 && ordy3) begin
            e = (q3.size() != 0) ? q3.pop_front() : 'x;
            chk("sb3", pk(int'(os3), int'(od3)), e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; in_last = '0;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        v3 = '0; l3 = '0; ordy3 = 1'b1; d3 = {8'h32, 8'h31, 8'h30};
        step(); step();
        half();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_sel", {30'd0, out_sel}, 32'd0);
        chk("rst_ready", {28'd0, in_ready}, 32'd0);
        tick();
        in_valid = '0; rst_n = 1'b1;
        step();
        // single channel ch2 = A5
        in_valid = 4'b0100; in_data[23:16] = 8'hA5; in_data[15:8] = 8'h11;
        q4.push_back(pk(2, 8'hA5));
        half();
        chk("single_ready", {28'd0, in_ready}, 32'b0100);
        tick();
        in_valid = 4'b1011; in_data[23:16] = 8'h12;
        q4.push_back(pk(3, 8'h13));
        half();
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("after_ch2_ready", {28'd0, in_ready}, 32'b1000);
        tick();
        in_valid = '0;
        step();
        // all channels continuously valid
        in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) q4.push_back(pk(i % 4, 8'h10 + (i % 4)));
        for (int i = 0; i < 5; i++) step();
        // backpressure, holding {0,10}
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("bp_ready", {28'd0, in_ready}, 32'd0);
            chk("bp_beat", pk(int'(out_sel), int'(out_data)), pk(0, 8'h10));
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        q4.push_back(pk(1, 8'h11));
        half();
        chk("bp_release_ready", {28'd0, in_ready}, 32'b0010);
        tick();
        in_valid = '0;
        step();
        chk("bp_idle", {31'd0, out_valid}, 32'd0);
        // move ptr to 1
        in_valid = 4'b0001; q4.push_back(pk(0, 8'h10));
        step();
        in_valid = '0;
        step();
        // packet lock: ch1 sends three beats, ch0/ch2 always valid
        k1 = 0;
`ifdef MUX_RR_LAST_LOCK_EN
        q4.push_back(pk(1, 8'h21)); q4.push_back(pk(1, 8'h22)); q4.push_back(pk(1, 8'h23));
        q4.push_back(pk(2, 8'h12)); q4.push_back(pk(0, 8'h10));
        for (int i = 0; i < 5; i++) begin
`else
        q4.push_back(pk(1, 8'h21)); q4.push_back(pk(2, 8'h12));
        q4.push_back(pk(0, 8'h10)); q4.push_back(pk(1, 8'h22));
        for (int i = 0; i < 4; i++) begin
`endif
            in_valid = {1'b0, 1'b1, k1 < 3, 1'b1};
            in_data[15:8] = c1_data[k1 < 3 ? k1 : 2];
            in_last = {2'b00, c1_last[k1 < 3 ? k1 : 2], 1'b0};
            half();
            adv = in_ready[1] && in_valid[1];
            tick();
            if (adv) k1++;
        end
        in_valid = '0; in_last = '0;
        step();
        step();
        // N_CH=3: move ptr to 2, then all valid
        v3 = 3'b010; q3.push_back(pk(1, 8'h31));
        step();
        v3 = 3'b111;
        q3.push_back(pk(2, 8'h32)); q3.push_back(pk(0, 8'h30)); q3.push_back(pk(1, 8'h31));
        for (int i = 0; i < 3; i++) step();
        v3 = '0;
        step();
        // asynchronous reset while a beat is held
        in_valid = 4'b0001;
        half();
        tick();
        out_ready = 1'b0;
        #2;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", {24'd0, out_data}, 32'd0);
        chk("arst_sel", {30'd0, out_sel}, 32'd0);
        chk("arst_ready", {28'd0, in_ready}, 32'd0);
        in_valid = '0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("q4_drained", q4.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
